axi_write_router: RTL and testbench
===================================

# axi_write_router

Write-path routing stage of the AXI interconnect, directly downstream of the write arbiter. It latches each arbiter grant as a master/slave index pair and routes that transaction's AW, W and B handshakes between the granted master and the addressed slave. Only one write is outstanding at a time. Grants to unmapped addresses are completed internally with a DECERR response. It also drives the payload-mux selects (sel_m, sel_s) used by the AWADDR/WDATA/WSTRB datapath muxes.

## Interface
- NUM_M, 3: number of masters
- NUM_S, 8: number of slaves; index NUM_S means "no slave"
- ID_BITS, 4: AXI ID width
- ACLK  in  1  clock
- ARESET  in  1  asynchronous, active-high reset
- grant_valid  in  1  arbiter has a selection this cycle
- grant_m  in  2  granted master index, 0..NUM_M-1
- grant_s  in  4  target slave index, 0..NUM_S-1; NUM_S = unmapped
- AWID_M  in  NUM_M*ID_BITS  per-master AWID
- AWVALID_M / WVALID_M / WLAST_M / BREADY_M  in  NUM_M each  master-side handshakes
- AWREADY_M / WREADY_M / BVALID_M  out  NUM_M each  master-side handshakes
- BRESP_M  out  2  response to the granted master
- BID_M  out  ID_BITS  ID returned to the granted master
- AWVALID_S / WVALID_S / BREADY_S  out  NUM_S each  slave-side handshakes
- AWREADY_S / WREADY_S / BVALID_S  in  NUM_S each  slave-side handshakes
- BRESP_S  in  NUM_S*2  per-slave response
- BID_S  in  NUM_S*ID_BITS  per-slave BID
- sel_m  out  2  registered master select for the payload muxes
- sel_s  out  4  registered slave select for the payload muxes
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, AW, W, B, ERR_W, ERR_B.
- IDLE, grant_valid=1:
  - Register grant_m into sel_m and grant_s into sel_s.
  - Capture AWID_M[grant_m].
  - Next state AW.
  - grant_valid is ignored in every other state.
- AW:
  - If sel_s<NUM_S: AWVALID_S[sel_s]=AWVALID_M[sel_m] and AWREADY_M[sel_m]=AWREADY_S[sel_s]. Go to W on handshake.
  - If sel_s==NUM_S: AWREADY_M[sel_m]=AWVALID_M[sel_m]. Go to ERR_W on handshake.
- W: WVALID_S[sel_s]=WVALID_M[sel_m] and WREADY_M[sel_m]=WREADY_S[sel_s]. Go to B on a handshake beat with WLAST_M[sel_m]=1.
- B:
  - BVALID_M[sel_m]=BVALID_S[sel_s] and BREADY_S[sel_s]=BREADY_M[sel_m].
  - BRESP_M and BID_M are taken from slave sel_s.
  - Go to IDLE on handshake.
- ERR_W: WREADY_M[sel_m]=1. Discard beats. Go to ERR_B on the WLAST beat.
- ERR_B:
  - BVALID_M[sel_m]=1, BRESP_M=2'b11 (DECERR), BID_M=captured AWID.
  - Go to IDLE on BREADY_M[sel_m].
- All non-selected valid/ready outputs are 0 in every state. No W beat is accepted before the AW handshake.
- Reset mid-transaction: the transaction is abandoned and the state returns to IDLE. No B response is ever issued for it.

## Timing
- Reset values:
  - state IDLE; sel_m=0, sel_s=0, captured AWID=0.
  - All *VALID_*, *READY_* outputs 0.
  - BRESP_M=0, BID_M=0, busy=0.
- Grant is registered: a grant at cycle N gives AW state at N+1.
- Handshake outputs are combinational from state plus the selected inputs. Zero added latency per channel.
- Minimum single-beat write with zero-wait slave and master:
  - Grant at cycle 0, AW handshake at 1, W at 2, B at 3.
  - IDLE at 4; the next grant is accepted at 4.
- A B handshake and a new grant_valid in the same cycle: the grant is ignored, and the arbiter re-presents it in IDLE.
- busy is registered from state; it rises the cycle after the grant.

## Structure
- Shared package axi_wr_pkg: state enum, NO_SLAVE index constant, RESP_OKAY/RESP_DECERR constants.
- Single module, no sub-module. The DECERR responder is two states of the same FSM.

## Test plan
- Reset asserted mid-W (state W, beat 2 of 4) -> state IDLE, all outputs 0 immediately, busy=0; no B on any master.
- Grant m=1, s=2, 1-beat write, slaves zero-wait -> AW at cycle 1, W at 2, BVALID_M[1] at 3 with BRESP_S[2] value, IDLE at 4.
- Grant m=0, s=5, 4-beat burst with WREADY_S[5] low on beats 2–3 -> exactly 4 beats forwarded; B only after WLAST; WREADY_M[0] mirrors the stalls.
- Grant m=2, s=NUM_S, AWID=4'hA, 2 beats -> both beats accepted; BVALID_M[2]=1, BRESP_M=2'b11, BID_M=4'hA.
- New grant_valid held high during states W/B with different indices -> sel_m/sel_s unchanged until IDLE; the grant takes effect one cycle after IDLE.
- WVALID_M asserted before AW handshake -> WREADY_M=0 and WVALID_S=0 until the cycle after the AW handshake.

Source files
------------

// File: rtl/axi_wr_pkg.sv
// Shared constants for the AXI write routing stage: FSM encoding, the no-slave
// index and the response codes.
package axi_wr_pkg;

    typedef logic [2:0] wr_state_t;

    localparam wr_state_t ST_IDLE  = 3'd0;
    localparam wr_state_t ST_AW    = 3'd1;
    localparam wr_state_t ST_W     = 3'd2;
    localparam wr_state_t ST_B     = 3'd3;
    localparam wr_state_t ST_ERR_W = 3'd4;
    localparam wr_state_t ST_ERR_B = 3'd5;

    localparam int        NUM_S_DEFAULT = 8;
    localparam logic [3:0] NO_SLAVE     = 4'(NUM_S_DEFAULT);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_write_router.sv
// Routes one outstanding AXI write (AW, W, B) between the granted master and the
// addressed slave; unmapped grants are absorbed and answered with DECERR.
module axi_write_router
    import axi_wr_pkg::*;
#(
    parameter int NUM_M   = 3,
    parameter int NUM_S   = NUM_S_DEFAULT,
    parameter int ID_BITS = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       grant_valid,
    input  logic [1:0]                 grant_m,
    input  logic [3:0]                 grant_s,
    input  logic [NUM_M*ID_BITS-1:0]   AWID_M,
    input  logic [NUM_M-1:0]           AWVALID_M,
    input  logic [NUM_M-1:0]           WVALID_M,
    input  logic [NUM_M-1:0]           WLAST_M,
    input  logic [NUM_M-1:0]           BREADY_M,
    output logic [NUM_M-1:0]           AWREADY_M,
    output logic [NUM_M-1:0]           WREADY_M,
    output logic [NUM_M-1:0]           BVALID_M,
    output logic [1:0]                 BRESP_M,
    output logic [ID_BITS-1:0]         BID_M,
    output logic [NUM_S-1:0]           AWVALID_S,
    output logic [NUM_S-1:0]           WVALID_S,
    output logic [NUM_S-1:0]           BREADY_S,
    input  logic [NUM_S-1:0]           AWREADY_S,
    input  logic [NUM_S-1:0]           WREADY_S,
    input  logic [NUM_S-1:0]           BVALID_S,
    input  logic [NUM_S*2-1:0]         BRESP_S,
    input  logic [NUM_S*ID_BITS-1:0]   BID_S,
    output logic [1:0]                 sel_m,
    output logic [3:0]                 sel_s,
    output logic                       busy
);

    localparam int S_W = $clog2(NUM_S);

    wr_state_t            r_state;
    wr_state_t            w_state_d;
    logic [1:0]           r_sel_m;
    logic [3:0]           r_sel_s;
    logic [ID_BITS-1:0]   r_awid;
    logic                 r_busy;

    logic                 w_mapped;
    logic [S_W-1:0]       w_s;

    // Any index at or above NUM_S is treated as unmapped, so w_s is only used when mapped.
    assign w_mapped = int'(r_sel_s) < NUM_S;
    assign w_s      = r_sel_s[S_W-1:0];

    assign sel_m = r_sel_m;
    assign sel_s = r_sel_s;
    assign busy  = r_busy;

    always_comb begin
        AWREADY_M = '0;
        WREADY_M  = '0;
        BVALID_M  = '0;
        BRESP_M   = '0;
        BID_M     = '0;
        AWVALID_S = '0;
        WVALID_S  = '0;
        BREADY_S  = '0;
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
                if (grant_valid) w_state_d = ST_AW;
            end
            ST_AW: begin
                if (w_mapped) begin
                    AWVALID_S[w_s]     = AWVALID_M[r_sel_m];
                    AWREADY_M[r_sel_m] = AWREADY_S[w_s];
                    if (AWVALID_M[r_sel_m] && AWREADY_S[w_s]) w_state_d = ST_W;
                end else begin
                    AWREADY_M[r_sel_m] = AWVALID_M[r_sel_m];
                    if (AWVALID_M[r_sel_m]) w_state_d = ST_ERR_W;
                end
            end
            ST_W: begin
                WVALID_S[w_s]     = WVALID_M[r_sel_m];
                WREADY_M[r_sel_m] = WREADY_S[w_s];
                if (WVALID_M[r_sel_m] && WREADY_S[w_s] && WLAST_M[r_sel_m]) w_state_d = ST_B;
            end
            ST_B: begin
                BVALID_M[r_sel_m] = BVALID_S[w_s];
                BREADY_S[w_s]     = BREADY_M[r_sel_m];
                BRESP_M           = BRESP_S[w_s*2 +: 2];
                BID_M             = BID_S[w_s*ID_BITS +: ID_BITS];
                if (BVALID_S[w_s] && BREADY_M[r_sel_m]) w_state_d = ST_IDLE;
            end
            ST_ERR_W: begin
                // Beats of an unmapped write are swallowed until WLAST.
                WREADY_M[r_sel_m] = 1'b1;
                if (WVALID_M[r_sel_m] && WLAST_M[r_sel_m]) w_state_d = ST_ERR_B;
            end
            ST_ERR_B: begin
                BVALID_M[r_sel_m] = 1'b1;
                BRESP_M           = RESP_DECERR;
                BID_M             = r_awid;
                if (BREADY_M[r_sel_m]) w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
            r_sel_m <= '0;
            r_sel_s <= '0;
            r_awid  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_busy  <= (w_state_d != ST_IDLE);
            if (r_state == ST_IDLE && grant_valid) begin
                r_sel_m <= grant_m;
                r_sel_s <= grant_s;
                r_awid  <= AWID_M[grant_m*ID_BITS +: ID_BITS];
            end
        end
    end

endmodule

// File: tb/tb_axi_write_router.sv
// Bench for axi_write_router: directed vector table, hand-built corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_axi_write_router;

    logic        ACLK, ARESET, grant_valid;
    logic [1:0]  grant_m;
    logic [3:0]  grant_s;
    logic [11:0] AWID_M;
    logic [2:0]  AWVALID_M, WVALID_M, WLAST_M, BREADY_M;
    logic [2:0]  AWREADY_M, WREADY_M, BVALID_M;
    logic [1:0]  BRESP_M;
    logic [3:0]  BID_M;
    logic [7:0]  AWVALID_S, WVALID_S, BREADY_S;
    logic [7:0]  AWREADY_S, WREADY_S, BVALID_S;
    logic [15:0] BRESP_S;
    logic [31:0] BID_S;
    logic [1:0]  sel_m;
    logic [3:0]  sel_s;
    logic        busy;

    axi_write_router dut (
        .ACLK(ACLK), .ARESET(ARESET), .grant_valid(grant_valid), .grant_m(grant_m),
        .grant_s(grant_s), .AWID_M(AWID_M), .AWVALID_M(AWVALID_M), .WVALID_M(WVALID_M),
        .WLAST_M(WLAST_M), .BREADY_M(BREADY_M), .AWREADY_M(AWREADY_M), .WREADY_M(WREADY_M),
        .BVALID_M(BVALID_M), .BRESP_M(BRESP_M), .BID_M(BID_M), .AWVALID_S(AWVALID_S),
        .WVALID_S(WVALID_S), .BREADY_S(BREADY_S), .AWREADY_S(AWREADY_S), .WREADY_S(WREADY_S),
        .BVALID_S(BVALID_S), .BRESP_S(BRESP_S), .BID_S(BID_S), .sel_m(sel_m), .sel_s(sel_s),
        .busy(busy)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int checks = 0;
    int errors = 0;
    int fwd_beats = 0;

    // Reference model: one outstanding transaction and which of its phases are done.
    bit         mdl_active, mdl_aw_done, mdl_w_done;
    int         mdl_m, mdl_s;
    logic [3:0] mdl_id;
    logic [1:0] mdl_sel_m;
    logic [3:0] mdl_sel_s;

    typedef struct {
        logic gv; logic [1:0] gm; logic [3:0] gs;
        logic [1:0] mi; logic [3:0] si;
        logic [3:0] min;   // {awvalid, wvalid, wlast, bready} on master mi
        logic [2:0] sin;   // {awready, wready, bvalid} on slave si
        logic [2:0] em;    // {awready, wready, bvalid} expected on master mi
        logic [2:0] es;    // {awvalid, wvalid, bready} expected on slave si
        logic [1:0] eresp; logic [3:0] eid;
        logic [1:0] esm; logic [3:0] ess; logic ebusy;
    } row_t;

    row_t tbl [12];

    function automatic row_t mk(logic gv, logic [1:0] gm, logic [3:0] gs, logic [1:0] mi,
                                logic [3:0] si, logic [3:0] min, logic [2:0] sin,
                                logic [2:0] em, logic [2:0] es, logic [1:0] eresp,
                                logic [3:0] eid, logic [1:0] esm, logic [3:0] ess,
                                logic ebusy);
        row_t r;
        r.gv = gv; r.gm = gm; r.gs = gs; r.mi = mi; r.si = si; r.min = min; r.sin = sin;
        r.em = em; r.es = es; r.eresp = eresp; r.eid = eid; r.esm = esm; r.ess = ess;
        r.ebusy = ebusy;
        return r;
    endfunction

    function automatic logic [45:0] dut_vec();
        return {AWREADY_M, WREADY_M, BVALID_M, BRESP_M, BID_M, AWVALID_S, WVALID_S, BREADY_S,
                sel_m, sel_s, busy};
    endfunction

    task automatic check(input string name, input logic [45:0] act, input logic [45:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_active = 0; mdl_aw_done = 0; mdl_w_done = 0;
        mdl_m = 0; mdl_s = 0; mdl_id = '0; mdl_sel_m = '0; mdl_sel_s = '0;
    endtask

    function automatic logic [45:0] model_exp();
        logic [2:0] awr = '0, wr = '0, bv = '0;
        logic [7:0] awv = '0, wv = '0, brs = '0;
        logic [1:0] rsp = '0;
        logic [3:0] id = '0;
        bit mapped;
        if (mdl_active) begin
            mapped = mdl_s < 8;
            if (!mdl_aw_done) begin
                if (mapped) begin
                    awv[mdl_s] = AWVALID_M[mdl_m];
                    awr[mdl_m] = AWREADY_S[mdl_s];
                end else begin
                    awr[mdl_m] = AWVALID_M[mdl_m];
                end
            end else if (!mdl_w_done) begin
                if (mapped) begin
                    wv[mdl_s] = WVALID_M[mdl_m];
                    wr[mdl_m] = WREADY_S[mdl_s];
                end else begin
                    wr[mdl_m] = 1'b1;
                end
            end else if (mapped) begin
                bv[mdl_m]  = BVALID_S[mdl_s];
                brs[mdl_s] = BREADY_M[mdl_m];
                rsp        = BRESP_S[2*mdl_s +: 2];
                id         = BID_S[4*mdl_s +: 4];
            end else begin
                bv[mdl_m] = 1'b1;
                rsp       = 2'b11;
                id        = mdl_id;
            end
        end
        return {awr, wr, bv, rsp, id, awv, wv, brs, mdl_sel_m, mdl_sel_s, 1'(mdl_active)};
    endfunction

    task automatic model_update();
        bit mapped;
        if (ARESET) begin
            model_reset();
        end else if (!mdl_active) begin
            if (grant_valid) begin
                mdl_active = 1; mdl_aw_done = 0; mdl_w_done = 0;
                mdl_m = int'(grant_m); mdl_s = int'(grant_s);
                mdl_id = AWID_M[4*grant_m +: 4];
                mdl_sel_m = grant_m; mdl_sel_s = grant_s;
            end
        end else begin
            mapped = mdl_s < 8;
            if (!mdl_aw_done) begin
                if (AWVALID_M[mdl_m] && (!mapped || AWREADY_S[mdl_s])) mdl_aw_done = 1;
            end else if (!mdl_w_done) begin
                if (WVALID_M[mdl_m] && WLAST_M[mdl_m] && (!mapped || WREADY_S[mdl_s]))
                    mdl_w_done = 1;
            end else begin
                if (BREADY_M[mdl_m] && (!mapped || BVALID_S[mdl_s])) mdl_active = 0;
            end
        end
    endtask

    // Compare between edges, then advance the model on the same inputs the DUT sampled.
    task automatic run_cycle(input string tag, input bit use_tbl, input logic [45:0] texp);
        @(negedge ACLK);
        #1;
        if (ARESET) model_reset();
        fwd_beats += $countones(WVALID_S & WREADY_S);
        check(tag, dut_vec(), use_tbl ? texp : model_exp());
        @(posedge ACLK);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        grant_valid = 0; grant_m = '0; grant_s = '0;
        AWVALID_M = '0; WVALID_M = '0; WLAST_M = '0; BREADY_M = '0;
        AWREADY_S = '0; WREADY_S = '0; BVALID_S = '0;
    endtask

    initial begin
        logic [45:0] texp;
        logic [5:0]  wpat;
        row_t r;
        ARESET = 1'b1;
        clear_inputs();
        AWID_M = 12'hA35;
        for (int i = 0; i < 8; i++) begin
            BRESP_S[2*i +: 2] = 2'(i);
            BID_S[4*i +: 4]   = 4'(i + 4);
        end
        model_reset();
        run_cycle("reset_state", 1'b1, '0);
        run_cycle("reset_state_model", 1'b0, '0);
        ARESET = 1'b0;

        // Single-beat m=1 s=2 zero-wait, then DECERR m=2 unmapped 2 beats.
        tbl[0]  = mk(1, 1, 2, 1, 2, 4'b1111, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 1, 2, 4'b1111, 3'b111, 3'b100, 3'b100, 0, 0, 1, 2, 1);
        tbl[2]  = mk(0, 0, 0, 1, 2, 4'b1111, 3'b111, 3'b010, 3'b010, 0, 0, 1, 2, 1);
        tbl[3]  = mk(1, 0, 3, 1, 2, 4'b1111, 3'b111, 3'b001, 3'b001, 2, 6, 1, 2, 1);
        tbl[4]  = mk(0, 0, 0, 1, 2, 4'b0000, 3'b000, 3'b000, 3'b000, 0, 0, 1, 2, 0);
        tbl[5]  = mk(1, 2, 8, 2, 8, 4'b1100, 3'b000, 3'b000, 3'b000, 0, 0, 1, 2, 0);
        tbl[6]  = mk(0, 0, 0, 2, 8, 4'b1100, 3'b000, 3'b100, 3'b000, 0, 0, 2, 8, 1);
        tbl[7]  = mk(0, 0, 0, 2, 8, 4'b0100, 3'b000, 3'b010, 3'b000, 0, 0, 2, 8, 1);
        tbl[8]  = mk(0, 0, 0, 2, 8, 4'b0110, 3'b000, 3'b010, 3'b000, 0, 0, 2, 8, 1);
        tbl[9]  = mk(0, 0, 0, 2, 8, 4'b0000, 3'b000, 3'b001, 3'b000, 3, 4'hA, 2, 8, 1);
        tbl[10] = mk(0, 0, 0, 2, 8, 4'b0001, 3'b000, 3'b001, 3'b000, 3, 4'hA, 2, 8, 1);
        tbl[11] = mk(0, 0, 0, 2, 8, 4'b0000, 3'b000, 3'b000, 3'b000, 0, 0, 2, 8, 0);
        for (int i = 0; i < 12; i++) begin
            r = tbl[i];
            grant_valid = r.gv; grant_m = r.gm; grant_s = r.gs;
            AWVALID_M = 3'(r.min[3]) << r.mi;
            WVALID_M  = 3'(r.min[2]) << r.mi;
            WLAST_M   = 3'(r.min[1]) << r.mi;
            BREADY_M  = 3'(r.min[0]) << r.mi;
            AWREADY_S = 8'(r.sin[2]) << r.si;
            WREADY_S  = 8'(r.sin[1]) << r.si;
            BVALID_S  = 8'(r.sin[0]) << r.si;
            texp = {(3'(r.em[2]) << r.mi), (3'(r.em[1]) << r.mi), (3'(r.em[0]) << r.mi),
                    r.eresp, r.eid, (8'(r.es[2]) << r.si), (8'(r.es[1]) << r.si),
                    (8'(r.es[0]) << r.si), r.esm, r.ess, r.ebusy};
            run_cycle($sformatf("table_row%0d", i), 1'b1, texp);
        end

        // Burst m=0 s=5: early WVALID, AW stall, W stalls on beats 2 and 3.
        clear_inputs();
        grant_valid = 1; grant_m = 0; grant_s = 5; AWVALID_M = 3'b001; WVALID_M = 3'b001;
        run_cycle("burst_grant", 1'b0, '0);
        grant_valid = 0;
        run_cycle("burst_aw_stall", 1'b0, '0);
        AWREADY_S = 8'h20;
        run_cycle("burst_aw", 1'b0, '0);
        AWVALID_M = '0; AWREADY_S = '0; fwd_beats = 0;
        wpat = 6'b110101;
        for (int k = 0; k < 6; k++) begin
            WREADY_S = wpat[k] ? 8'h20 : 8'h00;
            WLAST_M  = (fwd_beats == 3) ? 3'b001 : 3'b000;
            run_cycle($sformatf("burst_w%0d", k), 1'b0, '0);
        end
        check("burst_beat_count", 46'(fwd_beats), 46'd4);
        WVALID_M = '0; WLAST_M = '0; WREADY_S = '0; BREADY_M = 3'b001;
        run_cycle("burst_b_wait", 1'b0, '0);
        BVALID_S = 8'h20;
        run_cycle("burst_b", 1'b0, '0);
        clear_inputs();
        run_cycle("burst_idle", 1'b0, '0);

        // Grant held high with other indices while a transaction is in flight.
        grant_valid = 1; grant_m = 1; grant_s = 3; AWVALID_M = 3'b010; AWREADY_S = 8'h08;
        run_cycle("hold_grant", 1'b0, '0);
        grant_m = 2; grant_s = 6;
        run_cycle("hold_aw", 1'b0, '0);
        AWVALID_M = '0; AWREADY_S = '0; WVALID_M = 3'b010; WLAST_M = 3'b010; WREADY_S = 8'h08;
        run_cycle("hold_w", 1'b0, '0);
        WVALID_M = '0; WLAST_M = '0; WREADY_S = '0; BVALID_S = 8'h08; BREADY_M = 3'b010;
        run_cycle("hold_b", 1'b0, '0);
        check("hold_sel_kept", 46'({sel_m, sel_s, busy}), 46'({2'd1, 4'd3, 1'b0}));
        BVALID_S = '0; BREADY_M = '0;
        run_cycle("hold_regrant", 1'b0, '0);
        check("hold_sel_new", 46'({sel_m, sel_s, busy}), 46'({2'd2, 4'd6, 1'b1}));
        clear_inputs();
        ARESET = 1'b1;
        run_cycle("hold_reset", 1'b0, '0);
        ARESET = 1'b0;

        // Reset while beat 2 of a 4-beat write is being presented.
        grant_valid = 1; grant_m = 0; grant_s = 1;
        run_cycle("rst_grant", 1'b0, '0);
        grant_valid = 0; AWVALID_M = 3'b001; AWREADY_S = 8'h02;
        run_cycle("rst_aw", 1'b0, '0);
        AWVALID_M = '0; AWREADY_S = '0; WVALID_M = 3'b001; WREADY_S = 8'h02;
        run_cycle("rst_beat1", 1'b0, '0);
        ARESET = 1'b1;
        run_cycle("rst_beat2", 1'b0, '0);
        check("rst_all_zero", dut_vec(), '0);
        ARESET = 1'b0; WLAST_M = 3'b001; BVALID_S = 8'hFF; BREADY_M = 3'b111;
        for (int k = 0; k < 3; k++) begin
            run_cycle($sformatf("rst_after%0d", k), 1'b0, '0);
            check("rst_no_b", 46'(BVALID_M), 46'd0);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            ARESET      = ($urandom_range(0, 299) == 0);
            grant_valid = ($urandom_range(0, 3) == 0);
            grant_m     = 2'($urandom_range(0, 2));
            grant_s     = 4'($urandom_range(0, 8));
            AWID_M      = 12'($urandom);
            AWVALID_M   = 3'($urandom);
            WVALID_M    = 3'($urandom);
            WLAST_M     = 3'($urandom) & 3'($urandom);
            BREADY_M    = 3'($urandom);
            AWREADY_S   = 8'($urandom);
            WREADY_S    = 8'($urandom);
            BVALID_S    = 8'($urandom);
            BRESP_S     = 16'($urandom);
            BID_S       = $urandom;
            run_cycle("random", 1'b0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
